// File: rtl/frame_drawer.sv
// Frame drawer: erases the old ball, redraws four platforms and the new ball
// as a stream of registered VGA pixel writes.
module frame_drawer #(
  parameter int BALL_X   = 78,
  parameter int PLAT_X   = 72,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  prev_ball,
  input  logic [7:0]  curr_ball,
  input  logic [2:0]  color_ball,
  input  logic [27:0] position_plats,
  input  logic [11:0] color_plats,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_PLAT, S_BALL, S_DONE
  } state_t;

  localparam logic [7:0] BX = 8'(BALL_X);
  localparam logic [7:0] PX = 8'(PLAT_X);
  localparam logic [8:0] SH = 9'(SCREEN_H);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  prev_q, prev_d;
  logic [7:0]  curr_q, curr_d;
  logic [2:0]  cb_q, cb_d;
  logic [27:0] pp_q, pp_d;
  logic [11:0] cp_q, cp_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  base;
  logic [1:0]  row;
  logic [1:0]  pi;
  logic [8:0]  sum;
  logic        draw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    curr_d  = curr_q;
    cb_d    = cb_q;
    pp_d    = pp_q;
    cp_d    = cp_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          prev_d  = prev_ball;
          curr_d  = curr_ball;
          cb_d    = color_ball;
          pp_d    = position_plats;
          cp_d    = color_plats;
          state_d = S_ERASE;
          cnt_d   = '0;
        end
      end
      S_ERASE: begin
        if (cnt_q == 6'd15) begin
          state_d = S_PLAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_PLAT: begin
        if (cnt_q == 6'd63) begin
          state_d = S_BALL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_BALL: begin
        if (cnt_q == 6'd15) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pixel for the next cycle is derived from the next state so that the
  // registered outputs line up with the cycle that state is active.
  always_comb begin
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    plot_d   = 1'b0;
    base     = '0;
    row      = '0;
    draw     = 1'b0;
    pi       = cnt_d[5:4];
    unique case (state_d)
      S_ERASE: begin
        draw = 1'b1;
        base = prev_d;
        row  = cnt_d[3:2];
        x_d  = BX + {6'd0, cnt_d[1:0]};
      end
      S_PLAT: begin
        draw     = 1'b1;
        base     = {1'b0, pp_d[7*int'(pi) +: 7]};
        x_d      = PX + {4'd0, cnt_d[3:0]};
        colour_d = cp_d[3*int'(pi) +: 3];
      end
      S_BALL: begin
        draw     = 1'b1;
        base     = curr_d;
        row      = cnt_d[3:2];
        x_d      = BX + {6'd0, cnt_d[1:0]};
        colour_d = cb_d;
      end
      default: ;
    endcase
    sum = {1'b0, base} + {7'd0, row};
    if (draw) begin
      y_d    = sum[6:0];
      plot_d = (sum < SH);
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
      curr_q   <= '0;
      cb_q     <= '0;
      pp_q     <= '0;
      cp_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      curr_q   <= curr_d;
      cb_q     <= cb_d;
      pp_q     <= pp_d;
      cp_q     <= cp_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_frame_drawer.sv
// Scoreboard bench for frame_drawer: expected pixels/done cycles are queued
// at start time and consumed by an independent output monitor.
module tb_frame_drawer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  prev_ball = '0;
  logic [7:0]  curr_ball = '0;
  logic [2:0]  color_ball = '0;
  logic [27:0] position_plats = '0;
  logic [11:0] color_plats = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  frame_drawer dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .prev_ball(prev_ball),
    .curr_ball(curr_ball),
    .color_ball(color_ball),
    .position_plats(position_plats),
    .color_plats(color_plats),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_pix[$];
  int exp_done[$];
  int busy_from = -1;
  int busy_to = -2;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int n, input int pv, input int cu,
                            input logic [2:0] cb, input logic [27:0] pp,
                            input logic [11:0] cp);
    logic [27:0] sh;
    logic [11:0] csh;
    int pr;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pv + r < 120)
          exp_pix.push_back({8'(78 + c), 7'(pv + r), 3'b000});
    for (int i = 0; i < 4; i++) begin
      sh  = pp >> (7 * i);
      csh = cp >> (3 * i);
      pr  = int'(sh[6:0]);
      if (pr < 120)
        for (int c = 0; c < 16; c++)
          exp_pix.push_back({8'(72 + c), 7'(pr), csh[2:0]});
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (cu + r < 120)
          exp_pix.push_back({8'(78 + c), 7'(cu + r), cb});
    exp_done.push_back(n + 97);
    busy_from = n + 1;
    busy_to   = n + 97;
  endtask

  // Called just after a rising edge; start is seen by the next edge.
  task automatic start_frame(input int pv, input int cu,
                             input logic [2:0] cb, input logic [27:0] pp,
                             input logic [11:0] cp, output int n);
    prev_ball      = 8'(pv);
    curr_ball      = 8'(cu);
    color_ball     = cb;
    position_plats = pp;
    color_plats    = cp;
    start          = 1'b1;
    n              = cyc;
    push_frame(n, pv, cu, cb, pp, cp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_done.size() != 0 || busy) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL frame_timeout: got still busy, want idle within 500");
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [17:0] e;
      logic exp_b;
      if (plot) begin
        checks++;
        if (exp_pix.size() == 0) begin
          errors++;
          $display("FAIL pixel: got unexpected x=%0d y=%0d c=%0d at cyc %0d, want no plot",
                   x, y, colour, cyc);
        end else begin
          e = exp_pix.pop_front();
          if ({x, y, colour} !== e) begin
            errors++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d (cyc %0d)",
                     x, y, colour, e[17:10], e[9:3], e[2:0], cyc);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done: got unexpected done at cyc %0d, want none", cyc);
        end else if (exp_done[0] != cyc) begin
          errors++;
          $display("FAIL done: got cyc %0d, want cyc %0d", cyc, exp_done[0]);
          void'(exp_done.pop_front());
        end else begin
          void'(exp_done.pop_front());
        end
        checks++;
        if (exp_pix.size() != 0) begin
          errors++;
          $display("FAIL frame_pixels: got %0d missing, want 0", exp_pix.size());
          exp_pix.delete();
        end
      end
      exp_b = (cyc >= busy_from) && (cyc <= busy_to);
      checks++;
      if (busy !== exp_b) begin
        errors++;
        $display("FAIL busy: got %0b, want %0b (cyc %0d)", busy, exp_b, cyc);
      end
    end
  end

  initial begin
    int n;
    int n3;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_colour", int'(colour), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    start_frame(10, 9, 3'b100, {7'd100, 7'd80, 7'd60, 7'd40}, 12'hFAC, n);
    wait_idle();

    start_frame(118, 118, 3'b011, {7'd127, 7'd120, 7'd119, 7'd0}, 12'h5A3, n);
    wait_cyc(n + 5);
    start = 1'b1;
    prev_ball = 8'd50;
    curr_ball = 8'd50;
    color_ball = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc(n + 50);
    curr_ball = 8'd20;
    position_plats = {7'd1, 7'd2, 7'd3, 7'd4};
    wait_cyc(n + 97);
    start = 1'b1;
    color_plats = 12'h000;
    @(posedge clk); #1;
    start = 1'b0;
    start_frame(5, 100, 3'b010, {7'd110, 7'd90, 7'd30, 7'd5}, 12'h123, n3);
    chk("restart_cycle", n3 - n, 98);
    wait_idle();

    start_frame(30, 31, 3'b101, {7'd10, 7'd20, 7'd30, 7'd40}, 12'h777, n);
    wait_cyc(n + 40);
    resetn = 1'b0;
    @(posedge clk); #1;
    exp_pix.delete();
    exp_done.delete();
    busy_to = n + 40;
    chk("midreset_plot", int'(plot), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_x", int'(x), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    start_frame(64, 66, 3'b001, {7'd119, 7'd50, 7'd25, 7'd12}, 12'hBEE, n);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", exp_pix.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_drawer.md
FRAME_DRAWER -- requirements
Module: frame_drawer

Interface
REQ-001 SHALL have parameter BALL_X, default 78, meaning left column of the 4x4 ball sprite.
REQ-002 SHALL have parameter PLAT_X, default 72, meaning left column of every 16x1 platform.
REQ-003 SHALL have parameter SCREEN_H, default 120, meaning number of visible rows; rows >= SCREEN_H are clipped.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to redraw the frame.
REQ-007 prev_ball  input  8  row of the ball sprite to erase.
REQ-008 curr_ball  input  8  row of the ball sprite to draw.
REQ-009 color_ball  input  3  ball colour.
REQ-010 position_plats  input  28  four 7-bit platform rows; platform i = bits [7i+6:7i].
REQ-011 color_plats  input  12  four 3-bit platform colours; platform i = bits [3i+2:3i].
REQ-012 x  output  8  pixel column to VGA adapter.
REQ-013 y  output  7  pixel row to VGA adapter.
REQ-014 colour  output  3  pixel colour to VGA adapter.
REQ-015 plot  output  1  write-enable for the current x/y/colour.
REQ-016 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-017 done  output  1  one-cycle pulse when a frame is complete.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 States SHALL be IDLE, ERASE, PLAT, BALL, DONE.
REQ-020 In IDLE, start=1 SHALL latch all data inputs and move to ERASE; start in any other state SHALL be ignored.
REQ-021 ERASE SHALL issue 16 pixels: 4-bit counter c, col=c[1:0], row=c[3:2], x=BALL_X+col, y=prev_ball+row, colour=000.
REQ-022 PLAT SHALL issue 64 pixels: 6-bit counter p, i=p[5:4], col=p[3:0], x=PLAT_X+col, y=platform i row, colour=platform i colour; order i=0..3.
REQ-023 BALL SHALL issue 16 pixels as ERASE but with y=curr_ball+row and colour=color_ball.
REQ-024 DONE SHALL last one cycle with done=1, plot=0, then return to IDLE.
REQ-025 Timing: start accepted at cycle N -> pixels at N+1..N+16 (erase), N+17..N+80 (platforms), N+81..N+96 (ball), done at N+97; busy=1 for N+1..N+97.
REQ-026 Row sum SHALL be computed 9 bits wide; if sum >= SCREEN_H, plot=0 for that cycle while the counter still advances (no wrap-around onto row 0).
REQ-027 A platform row >= SCREEN_H SHALL suppress plot for all 16 of its pixels.
REQ-028 Latched inputs SHALL hold for the whole frame; input changes during busy SHALL have no effect.
REQ-029 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-030 plot SHALL be 0 in IDLE and DONE.

Reset
REQ-031 resetn=0 at any rising edge SHALL force IDLE, counters=0, x=0, y=0, colour=0, plot=0, busy=0, done=0 on the next cycle, including mid-frame.
REQ-032 The first start after resetn returns to 1 SHALL produce a complete frame per REQ-025.

Verification
REQ-033 Reset, then start with prev_ball=10, curr_ball=9, color_ball=3'b100 -> erase (78..81,10..13) colour 0; ball (78..81,9..12) colour 100; done at N+97.
REQ-034 position_plats={7'd100,7'd80,7'd60,7'd40}, color_plats=12'hFAC -> 64 plots; platform 0 row 40 colour 100, x 72..87; platform 3 row 100 colour 111.
REQ-035 curr_ball=118 -> rows 118,119 plotted; rows 120,121 have plot=0; done still at N+97.
REQ-036 start pulses at N+5 and N+97 -> both ignored, no second frame; start at N+98 -> new frame, done at N+195.
REQ-037 resetn=0 at N+40 (mid PLAT) -> next cycle plot=0, busy=0, state IDLE; later start draws a full frame.
REQ-038 curr_ball changed at N+50 -> ball pixels still use the value latched at N.
